// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Purpose  : Multi-request elevator car controller. Hall requests
//            (src, dest, dir) are stored in MAX_REQ slots and one car is
//            driven with a SCAN (collective) policy. Per-floor travel time
//            and door dwell are modelled internally.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_src    in   pickup floor
//   req_dest   in   destination floor
//   req_dir    in   1 = up, 0 = down
//   req_ready  out  at least one slot is free
//   req_slot   out  lowest free slot index (valid while req_ready)
//   req_err    out  1-cycle pulse: last offered request was illegal
//   ev_floor   out  current car floor
//   ev_door    out  1 = door open
//   ev_dir     out  00 stopped, 01 moving up, 10 moving down
//   done_mask  out  1-cycle pulse per slot whose passenger alighted
//   busy       out  any slot in use or car not idle
// ============================================================================
module elevator_scheduler #(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int MAX_REQ     = 4,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 6,
    // Derived slot index width; leave at its default.
    parameter int SLOT_W      = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [FLOOR_W-1:0]   req_src,
    input  logic [FLOOR_W-1:0]   req_dest,
    input  logic                 req_dir,
    output logic                 req_ready,
    output logic [SLOT_W-1:0]    req_slot,
    output logic                 req_err,
    output logic [FLOOR_W-1:0]   ev_floor,
    output logic                 ev_door,
    output logic [1:0]           ev_dir,
    output logic [MAX_REQ-1:0]   done_mask,
    output logic                 busy
);

    localparam int c_MOVE_W = $clog2(MOVE_CYCLES + 1);
    localparam int c_DOOR_W = $clog2(DOOR_CYCLES + 1);

    localparam logic [FLOOR_W:0]    c_FLOORS_EXT = (FLOOR_W+1)'(FLOORS);
    localparam logic [FLOOR_W-1:0]  c_TOP_FLOOR  = FLOOR_W'(FLOORS - 1);
    localparam logic [c_MOVE_W-1:0] c_MOVE_LAST  = c_MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [c_DOOR_W-1:0] c_DOOR_LAST  = c_DOOR_W'(DOOR_CYCLES - 1);

    // Slot life cycle
    localparam logic [1:0] c_SLOT_FREE = 2'd0;
    localparam logic [1:0] c_SLOT_WAIT = 2'd1;
    localparam logic [1:0] c_SLOT_RIDE = 2'd2;

    // Car states
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_MOVE_UP = 2'd1;
    localparam logic [1:0] c_ST_MOVE_DN = 2'd2;
    localparam logic [1:0] c_ST_DOOR    = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_last_dir;
    logic                w_last_dir_nxt;

    logic [1:0]          r_slot_st [MAX_REQ];
    logic [FLOOR_W-1:0]  r_src     [MAX_REQ];
    logic [FLOOR_W-1:0]  r_dest    [MAX_REQ];

    logic [c_MOVE_W-1:0] r_move_cnt;
    logic [c_DOOR_W-1:0] r_door_cnt;
    logic [FLOOR_W-1:0]  r_ev_floor;
    logic                r_req_err;
    logic [MAX_REQ-1:0]  r_done_mask;

    logic [MAX_REQ-1:0]  w_free;
    logic [MAX_REQ-1:0]  w_board;
    logic [MAX_REQ-1:0]  w_alight;
    logic [SLOT_W-1:0]   w_req_slot;
    logic                w_legal;
    logic                w_accept;

    logic [FLOORS-1:0]   w_stop_at;
    logic [FLOOR_W-1:0]  w_floor_up1;
    logic [FLOOR_W-1:0]  w_floor_dn1;
    logic                w_stop_here;
    logic                w_stop_up1;
    logic                w_stop_dn1;
    logic                w_ahead_up;
    logic                w_ahead_dn;

    logic                w_at_top;
    logic                w_at_bot;
    logic                w_moving;
    logic                w_move_last;
    logic                w_step_up;
    logic                w_step_dn;
    logic                w_door_activity;

    // ------------------------------------------------------------------
    // Per-slot status. Boarding/alighting only happens with the door open
    // and is judged on the pre-edge slot state, so one slot never boards
    // and alights on the same edge.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_slot
        assign w_free[gi]   = (r_slot_st[gi] == c_SLOT_FREE);
        assign w_board[gi]  = (r_state == c_ST_DOOR) &&
                              (r_slot_st[gi] == c_SLOT_WAIT) &&
                              (r_src[gi] == r_ev_floor);
        assign w_alight[gi] = (r_state == c_ST_DOOR) &&
                              (r_slot_st[gi] == c_SLOT_RIDE) &&
                              (r_dest[gi] == r_ev_floor);
    end

    // Lowest free slot: descending scan so the smallest index wins.
    always_comb begin
        w_req_slot = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_req_slot = SLOT_W'(i);
            end
        end
    end

    assign w_legal  = (req_src != req_dest) &&
                      ({1'b0, req_src}  < c_FLOORS_EXT) &&
                      ({1'b0, req_dest} < c_FLOORS_EXT) &&
                      ((req_dest > req_src) == req_dir);
    // req_ready comes from registered slot state, so a slot freed on this
    // edge is only offered from the next cycle on.
    assign w_accept = req_valid && (|w_free) && w_legal;

    // ------------------------------------------------------------------
    // Stop map: a floor is a stop if someone waits there or rides to it.
    // ------------------------------------------------------------------
    always_comb begin
        w_stop_at = '0;
        for (int f = 0; f < FLOORS; f++) begin
            for (int i = 0; i < MAX_REQ; i++) begin
                if (((r_slot_st[i] == c_SLOT_WAIT) && (r_src[i]  == FLOOR_W'(f))) ||
                    ((r_slot_st[i] == c_SLOT_RIDE) && (r_dest[i] == FLOOR_W'(f)))) begin
                    w_stop_at[f] = 1'b1;
                end
            end
        end
    end

    assign w_floor_up1 = r_ev_floor + FLOOR_W'(1);
    assign w_floor_dn1 = r_ev_floor - FLOOR_W'(1);

    always_comb begin
        w_stop_here = 1'b0;
        w_stop_up1  = 1'b0;
        w_stop_dn1  = 1'b0;
        w_ahead_up  = 1'b0;
        w_ahead_dn  = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            if (w_stop_at[f]) begin
                if (FLOOR_W'(f) == r_ev_floor)  w_stop_here = 1'b1;
                if (FLOOR_W'(f) >  r_ev_floor)  w_ahead_up  = 1'b1;
                if (FLOOR_W'(f) <  r_ev_floor)  w_ahead_dn  = 1'b1;
                if (FLOOR_W'(f) == w_floor_up1) w_stop_up1  = 1'b1;
                if (FLOOR_W'(f) == w_floor_dn1) w_stop_dn1  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Motion helpers. The end-floor guards keep the car inside the shaft
    // even if a move state were ever entered with nothing ahead.
    // ------------------------------------------------------------------
    assign w_at_top    = (r_ev_floor == c_TOP_FLOOR);
    assign w_at_bot    = (r_ev_floor == '0);
    assign w_moving    = ((r_state == c_ST_MOVE_UP) && !w_at_top) ||
                         ((r_state == c_ST_MOVE_DN) && !w_at_bot);
    assign w_move_last = (r_move_cnt == c_MOVE_LAST);
    assign w_step_up   = (r_state == c_ST_MOVE_UP) && !w_at_top && w_move_last;
    assign w_step_dn   = (r_state == c_ST_MOVE_DN) && !w_at_bot && w_move_last;

    // Anything happening at the open door restarts the dwell.
    assign w_door_activity = (|w_board) || (|w_alight) ||
                             (w_accept && (req_src == r_ev_floor));

    // ------------------------------------------------------------------
    // Car FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_last_dir <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_last_dir <= w_last_dir_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Car FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_last_dir_nxt = r_last_dir;
        case (r_state)
            c_ST_IDLE: begin
                if (w_stop_here) begin
                    w_state_nxt = c_ST_DOOR;
                end else if (r_last_dir ? w_ahead_up : w_ahead_dn) begin
                    w_state_nxt = r_last_dir ? c_ST_MOVE_UP : c_ST_MOVE_DN;
                end else if (r_last_dir ? w_ahead_dn : w_ahead_up) begin
                    w_state_nxt    = r_last_dir ? c_ST_MOVE_DN : c_ST_MOVE_UP;
                    w_last_dir_nxt = !r_last_dir;
                end
            end
            c_ST_MOVE_UP: begin
                if (w_at_top) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_move_last) begin
                    // Without a stop on the new floor, "ahead of old floor"
                    // equals "ahead of new floor".
                    if (w_stop_up1)      w_state_nxt = c_ST_DOOR;
                    else if (w_ahead_up) w_state_nxt = c_ST_MOVE_UP;
                    else                 w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_MOVE_DN: begin
                if (w_at_bot) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_move_last) begin
                    if (w_stop_dn1)      w_state_nxt = c_ST_DOOR;
                    else if (w_ahead_dn) w_state_nxt = c_ST_MOVE_DN;
                    else                 w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_DOOR: begin
                if (!w_door_activity && (r_door_cnt == c_DOOR_LAST)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Car FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ev_door = 1'b0;
        ev_dir  = 2'b00;
        case (r_state)
            c_ST_MOVE_UP: ev_dir  = 2'b01;
            c_ST_MOVE_DN: ev_dir  = 2'b10;
            c_ST_DOOR:    ev_door = 1'b1;
            default:      ev_dir  = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Travel timer and floor position
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_move_cnt <= '0;
            r_ev_floor <= '0;
        end else begin
            if (w_moving) begin
                r_move_cnt <= w_move_last ? '0 : r_move_cnt + c_MOVE_W'(1);
            end else begin
                r_move_cnt <= '0;
            end
            if (w_step_up) begin
                r_ev_floor <= w_floor_up1;
            end else if (w_step_dn) begin
                r_ev_floor <= w_floor_dn1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Door dwell timer: counts quiet cycles while the door is open.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_door_cnt <= '0;
        end else if ((r_state != c_ST_DOOR) || w_door_activity ||
                     (r_door_cnt == c_DOOR_LAST)) begin
            r_door_cnt <= '0;
        end else begin
            r_door_cnt <= r_door_cnt + c_DOOR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Request slots, completion pulses and error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_REQ; i++) begin
                r_slot_st[i] <= c_SLOT_FREE;
                r_src[i]     <= '0;
                r_dest[i]    <= '0;
            end
            r_done_mask <= '0;
            r_req_err   <= 1'b0;
        end else begin
            r_done_mask <= w_alight;
            r_req_err   <= req_valid && !w_legal;
            for (int i = 0; i < MAX_REQ; i++) begin
                if (w_accept && (w_req_slot == SLOT_W'(i))) begin
                    r_slot_st[i] <= c_SLOT_WAIT;
                    r_src[i]     <= req_src;
                    r_dest[i]    <= req_dest;
                end else if (w_board[i]) begin
                    r_slot_st[i] <= c_SLOT_RIDE;
                end else if (w_alight[i]) begin
                    r_slot_st[i] <= c_SLOT_FREE;
                end
            end
        end
    end

    assign req_ready = |w_free;
    assign req_slot  = w_req_slot;
    assign req_err   = r_req_err;
    assign ev_floor  = r_ev_floor;
    assign done_mask = r_done_mask;
    assign busy      = (~&w_free) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Purpose  : Directed self-checking bench for elevator_scheduler with
//            hand-computed expected values (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_elevator_scheduler;

    localparam int c_BUDGET = 300;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_src;
    logic [2:0] req_dest;
    logic       req_dir;
    logic       req_ready;
    logic [1:0] req_slot;
    logic       req_err;
    logic [2:0] ev_floor;
    logic       ev_door;
    logic [1:0] ev_dir;
    logic [3:0] done_mask;
    logic       busy;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] done_acc = '0;

    elevator_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_src   (req_src),
        .req_dest  (req_dest),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .req_slot  (req_slot),
        .req_err   (req_err),
        .ev_floor  (ev_floor),
        .ev_door   (ev_door),
        .ev_dir    (ev_dir),
        .done_mask (done_mask),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            done_acc = done_acc | done_mask;
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [2:0] d, input logic dir);
        req_valid = 1'b1;
        req_src   = s;
        req_dest  = d;
        req_dir   = dir;
    endtask

    task automatic release_req();
        req_valid = 1'b0;
    endtask

    task automatic wait_open(input logic [2:0] f, input string tag);
        int n = 0;
        while (ev_door !== 1'b1 && n < c_BUDGET) begin
            tick(1);
            n++;
        end
        `CHK(tag, {ev_door, ev_floor}, {1'b1, f});
    endtask

    task automatic wait_close(input string tag);
        int n = 0;
        while (ev_door !== 1'b0 && n < c_BUDGET) begin
            tick(1);
            n++;
        end
        `CHK(tag, ev_door, 1'b0);
    endtask

    task automatic wait_idle(input logic [2:0] f, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < c_BUDGET) begin
            tick(1);
            n++;
        end
        `CHK(tag, {busy, ev_floor}, {1'b0, f});
    endtask

    initial begin
        int   n;
        logic leak;

        rst_n = 1'b0;
        release_req();
        req_src  = '0;
        req_dest = '0;
        req_dir  = 1'b0;

        tick(2);
        checks++;
        if (ev_floor !== 3'd0) begin
            failures++;
            $error("FAIL rst_floor: observed=%0h expected=%0h", ev_floor, 3'd0);
        end
        checks++;
        if ({ev_door, ev_dir} !== 3'b000) begin
            failures++;
            $error("FAIL rst_door_dir: observed=%0h expected=%0h", {ev_door, ev_dir}, 3'b000);
        end
        `CHK("rst_ready_slot", {req_ready, req_slot}, 3'b100);
        `CHK("rst_busy_err_done", {busy, req_err, done_mask}, 6'b000000);
        rst_n = 1'b1;
        tick(1);

        drive(3'd2, 3'd5, 1'b1);
        tick(1);
        release_req();
        `CHK("t1_accept", {busy, ev_dir, req_slot}, {1'b1, 2'b00, 2'd1});
        tick(1);
        checks++;
        if ({ev_dir, ev_floor} !== {2'b01, 3'd0}) begin
            failures++;
            $error("FAIL t1_move_up: observed=%0h expected=%0h", {ev_dir, ev_floor}, {2'b01, 3'd0});
        end
        tick(3);
        checks++;
        if (ev_floor !== 3'd0) begin
            failures++;
            $error("FAIL t1_floor0_hold: observed=%0h expected=%0h", ev_floor, 3'd0);
        end
        tick(1);
        checks++;
        if (ev_floor !== 3'd1) begin
            failures++;
            $error("FAIL t1_floor1: observed=%0h expected=%0h", ev_floor, 3'd1);
        end
        tick(4);
        checks++;
        if ({ev_door, ev_dir, ev_floor} !== {1'b1, 2'b00, 3'd2}) begin
            failures++;
            $error("FAIL t1_door_at2: observed=%0h expected=%0h", {ev_door, ev_dir, ev_floor}, {1'b1, 2'b00, 3'd2});
        end
        tick(6);
        `CHK("t1_door_still_open", ev_door, 1'b1);
        tick(1);
        `CHK("t1_door_closed", {ev_door, ev_dir}, 3'b000);
        tick(1);
        `CHK("t1_resume_up", ev_dir, 2'b01);
        tick(12);
        `CHK("t1_door_at5", {ev_door, ev_floor}, {1'b1, 3'd5});
        tick(1);
        checks++;
        if (done_mask !== 4'b0001) begin
            failures++;
            $error("FAIL t1_done0: observed=%0h expected=%0h", done_mask, 4'b0001);
        end
        tick(1);
        `CHK("t1_done_cleared", done_mask, 4'b0000);
        tick(4);
        `CHK("t1_busy_before_close", busy, 1'b1);
        tick(1);
        `CHK("t1_idle", {busy, ev_door, ev_floor}, {1'b0, 1'b0, 3'd5});

        drive(3'd3, 3'd3, 1'b1);
        tick(1);
        release_req();
        `CHK("t2_err_same", {req_err, req_ready, req_slot, busy}, {1'b1, 1'b1, 2'd0, 1'b0});
        tick(1);
        `CHK("t2_err_clear", req_err, 1'b0);
        drive(3'd5, 3'd1, 1'b1);
        tick(1);
        release_req();
        `CHK("t2_err_dir", {req_err, req_ready, req_slot, busy}, {1'b1, 1'b1, 2'd0, 1'b0});
        tick(1);
        `CHK("t2_err_clear2", {req_err, busy}, 2'b00);

        drive(3'd5, 3'd6, 1'b1); tick(1);
        drive(3'd6, 3'd7, 1'b1); tick(1);
        drive(3'd7, 3'd6, 1'b0); tick(1);
        drive(3'd6, 3'd5, 1'b0); tick(1);
        `CHK("t3_full", {req_ready, busy}, 2'b01);
        drive(3'd5, 3'd4, 1'b0);
        leak = 1'b0;
        n = 0;
        while (done_mask == 4'b0000 && n < c_BUDGET) begin
            if (req_ready !== 1'b0) leak = 1'b1;
            tick(1);
            n++;
        end
        `CHK("t3_no_ready_while_full", leak, 1'b0);
        `CHK("t3_first_done", {done_mask, ev_floor}, {4'b0001, 3'd6});
        `CHK("t3_slot_reoffered", {req_ready, req_slot}, {1'b1, 2'd0});
        tick(1);
        release_req();
        `CHK("t3_fifth_taken", req_ready, 1'b0);
        done_acc = '0;
        wait_close("t3_close6");
        wait_open(3'd7, "t3_open7");
        wait_close("t3_close7");
        wait_open(3'd6, "t3_open6");
        wait_close("t3_close6b");
        wait_open(3'd5, "t3_open5");
        wait_close("t3_close5");
        wait_open(3'd4, "t3_open4");

        `CHK("t5a_slot_free", req_slot, 2'd1);
        drive(3'd1, 3'd0, 1'b0);
        tick(1);
        `CHK("t5a_done_fifth", done_mask, 4'b0001);
        `CHK("t3_all_done", done_acc, 4'b1111);
        `CHK("t5a_slot_next", req_slot, 2'd0);
        drive(3'd6, 3'd7, 1'b1);
        tick(1);
        release_req();
        wait_close("t5a_close4");
        tick(1);
        `CHK("t5a_goes_down", ev_dir, 2'b10);
        wait_open(3'd1, "t5a_visit1");
        wait_close("t5a_c1");
        wait_open(3'd0, "t5a_visit0");
        wait_close("t5a_c0");
        wait_open(3'd6, "t5a_visit6");
        wait_close("t5a_c6");
        wait_open(3'd7, "t5a_visit7");
        wait_idle(3'd7, "t5a_idle");

        drive(3'd3, 3'd4, 1'b1);
        tick(1);
        release_req();
        wait_open(3'd3, "t5b_open3");
        wait_close("t5b_c3");
        wait_open(3'd4, "t5b_open4");
        drive(3'd1, 3'd0, 1'b0);
        tick(1);
        drive(3'd6, 3'd7, 1'b1);
        tick(1);
        release_req();
        wait_close("t5b_close4");
        tick(1);
        `CHK("t5b_goes_up", ev_dir, 2'b01);
        wait_open(3'd6, "t5b_visit6");
        wait_close("t5b_c6");
        wait_open(3'd7, "t5b_visit7");
        wait_close("t5b_c7");
        wait_open(3'd1, "t5b_visit1");
        wait_close("t5b_c1");
        wait_open(3'd0, "t5b_visit0");
        wait_idle(3'd0, "t5b_idle");

        drive(3'd0, 3'd6, 1'b1);
        tick(1);
        release_req();
        wait_open(3'd0, "t4_open0");
        wait_close("t4_c0");
        tick(1);
        `CHK("t4_moving_up", {ev_dir, ev_floor}, {2'b01, 3'd0});
        tick(2);
        drive(3'd3, 3'd4, 1'b1);
        tick(1);
        release_req();
        wait_open(3'd3, "t4_visit3");
        wait_close("t4_c3");
        wait_open(3'd4, "t4_visit4");
        wait_close("t4_c4");
        wait_open(3'd6, "t4_visit6");
        wait_idle(3'd6, "t4_idle");

        drive(3'd2, 3'd5, 1'b1);
        tick(1);
        release_req();
        wait_open(3'd2, "t6_open2");
        n = 0;
        while (!(ev_floor == 3'd3 && ev_dir == 2'b01) && n < c_BUDGET) begin
            tick(1);
            n++;
        end
        `CHK("t6_at3_up", {ev_dir, ev_floor}, {2'b01, 3'd3});
        rst_n = 1'b0;
        tick(1);
        checks++;
        if ({ev_floor, ev_door, ev_dir} !== {3'd0, 1'b0, 2'b00}) begin
            failures++;
            $error("FAIL t6_rst_floor_door: observed=%0h expected=%0h", {ev_floor, ev_door, ev_dir}, {3'd0, 1'b0, 2'b00});
        end
        checks++;
        if ({req_ready, req_slot, busy, done_mask} !== {1'b1, 2'd0, 1'b0, 4'b0000}) begin
            failures++;
            $error("FAIL t6_rst_slots: observed=%0h expected=%0h", {req_ready, req_slot, busy, done_mask}, {1'b1, 2'd0, 1'b0, 4'b0000});
        end
        rst_n = 1'b1;
        tick(10);
        `CHK("t6_dropped", {busy, ev_floor, ev_dir}, {1'b0, 3'd0, 2'b00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
